// File: rtl/if_fetch.sv
// if_fetch -- instruction-fetch stage.
// Keeps the fetch PC, requests instructions over a req/ready handshake and
// hands inst/pc/instValid to the IF/ID boundary. A one-entry skid buffer
// absorbs a response that lands while ID is stalled. Jumps redirect the PC.
// A request still waiting when a jump arrives is completed in DRAIN and its
// data discarded, so the memory handshake is never broken.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   stall              ID cannot take a new instruction this cycle
//   jumpEn, jumpAddr   one-cycle redirect pulse and target (bits [1:0] ignored)
//   imemReq, imemAddr  memory request and word-aligned address
//   imemReady          response for the outstanding request is on imemData
//   imemData           returned instruction
//   inst, instValid    instruction to ID and its valid flag (0 = bubble)
//   pc                 address of inst
module if_fetch #(
  parameter int unsigned             INST_LENGTH = 32,
  parameter int unsigned             ADDR_LENGTH = 32,
  parameter logic [ADDR_LENGTH-1:0]  RESET_PC    = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    jumpEn,
  input  logic [ADDR_LENGTH-1:0]  jumpAddr,
  output logic                    imemReq,
  output logic [ADDR_LENGTH-1:0]  imemAddr,
  input  logic                    imemReady,
  input  logic [INST_LENGTH-1:0]  imemData,
  output logic [INST_LENGTH-1:0]  inst,
  output logic                    instValid,
  output logic [ADDR_LENGTH-1:0]  pc
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DRAIN,
    S_SKID
  } state_e;

  state_e                  state_q,      state_d;
  logic [ADDR_LENGTH-1:0]  fetch_pc_q,   fetch_pc_d;
  logic [ADDR_LENGTH-1:0]  drain_addr_q, drain_addr_d;
  logic [ADDR_LENGTH-1:0]  pc_q,         pc_d;
  logic [ADDR_LENGTH-1:0]  skid_pc_q,    skid_pc_d;
  logic [INST_LENGTH-1:0]  inst_q,       inst_d;
  logic [INST_LENGTH-1:0]  skid_q,       skid_d;
  logic                    inst_valid_q, inst_valid_d;
  logic                    pending_q,    pending_d;

  logic [ADDR_LENGTH-1:0]  jump_tgt;
  logic [ADDR_LENGTH-1:0]  pc_inc;

  assign jump_tgt = jumpAddr & ~ADDR_LENGTH'(3);
  assign pc_inc   = fetch_pc_q + ADDR_LENGTH'(4);

  // Memory request side. Once raised in FETCH the request is held by
  // pending_q until ready, regardless of stall.
  always_comb begin
    imemReq  = 1'b0;
    imemAddr = fetch_pc_q;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: imemReq = pending_q | ~stall;
        S_DRAIN: begin
          imemReq  = 1'b1;
          imemAddr = drain_addr_q;
        end
        default: imemReq = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    pc_d         = pc_q;
    skid_pc_d    = skid_pc_q;
    inst_d       = inst_q;
    skid_d       = skid_q;
    inst_valid_d = inst_valid_q;
    pending_d    = pending_q;

    unique case (state_q)
      S_FETCH: begin
        pending_d = imemReq & ~imemReady;
        if (jumpEn) begin
          fetch_pc_d   = jump_tgt;
          inst_d       = '0;
          inst_valid_d = 1'b0;
          if (imemReq && !imemReady) begin
            // Request cannot be withdrawn; DRAIN owns it from here.
            drain_addr_d = fetch_pc_q;
            pending_d    = 1'b0;
            state_d      = S_DRAIN;
          end
        end else if (imemReq && imemReady) begin
          fetch_pc_d = pc_inc;
          if (!stall) begin
            inst_d       = imemData;
            pc_d         = fetch_pc_q;
            inst_valid_d = 1'b1;
          end else begin
            skid_d    = imemData;
            skid_pc_d = fetch_pc_q;
            state_d   = S_SKID;
          end
        end else if (!stall) begin
          inst_d       = '0;
          inst_valid_d = 1'b0;
        end
      end

      S_DRAIN: begin
        inst_valid_d = 1'b0;
        if (jumpEn) fetch_pc_d = jump_tgt;
        if (imemReady) state_d = S_FETCH;
      end

      S_SKID: begin
        if (jumpEn) begin
          fetch_pc_d   = jump_tgt;
          inst_d       = '0;
          inst_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (!stall) begin
          inst_d       = skid_q;
          pc_d         = skid_pc_q;
          inst_valid_d = 1'b1;
          state_d      = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= '0;
      pc_q         <= '0;
      skid_pc_q    <= '0;
      inst_q       <= '0;
      skid_q       <= '0;
      inst_valid_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      pc_q         <= pc_d;
      skid_pc_q    <= skid_pc_d;
      inst_q       <= inst_d;
      skid_q       <= skid_d;
      inst_valid_q <= inst_valid_d;
      pending_q    <= pending_d;
    end
  end

  assign inst      = inst_q;
  assign instValid = inst_valid_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. u_dut talks to a memory that returns the
// request address as data after mem_wait extra cycles; u_dut_wrap uses
// RESET_PC = fffffff8 with a zero-wait memory to exercise PC wrap.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jumpEn;
  logic [31:0] jumpAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] inst;
  logic        instValid;
  logic [31:0] pc;

  logic        imemReq2;
  logic [31:0] imemAddr2;
  logic [31:0] inst2;
  logic        instValid2;
  logic [31:0] pc2;

  int unsigned mem_wait;
  int unsigned wcnt;

  int errors = 0;
  int checks = 0;

  if_fetch #(
    .INST_LENGTH (32),
    .ADDR_LENGTH (32),
    .RESET_PC    (32'h0000_0000)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .jumpEn    (jumpEn),
    .jumpAddr  (jumpAddr),
    .imemReq   (imemReq),
    .imemAddr  (imemAddr),
    .imemReady (imemReady),
    .imemData  (imemData),
    .inst      (inst),
    .instValid (instValid),
    .pc        (pc)
  );

  if_fetch #(
    .INST_LENGTH (32),
    .ADDR_LENGTH (32),
    .RESET_PC    (32'hffff_fff8)
  ) u_dut_wrap (
    .clk       (clk),
    .rst       (rst),
    .stall     (1'b0),
    .jumpEn    (1'b0),
    .jumpAddr  (32'h0),
    .imemReq   (imemReq2),
    .imemAddr  (imemAddr2),
    .imemReady (imemReq2),
    .imemData  (imemAddr2),
    .inst      (inst2),
    .instValid (instValid2),
    .pc        (pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ready once the current request has waited mem_wait cycles.
  assign imemReady = imemReq && (wcnt >= mem_wait);
  assign imemData  = imemAddr;

  always @(posedge clk) begin
    if (rst || !imemReq || imemReady) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jumpEn = 1'b0; jumpAddr = '0; mem_wait = 0;
    step();
    step();

    // Reset state, rst still high
    check("rst_valid", {31'b0, instValid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_req", {31'b0, imemReq}, 32'd0);
    check("rst_req2", {31'b0, imemReq2}, 32'd0);

    // Free run, zero-wait
    rst = 1'b0; #1;
    check("run_req0", {31'b0, imemReq}, 32'd1);
    check("run_addr0", imemAddr, 32'h0);
    check("wrap_addr0", imemAddr2, 32'hffff_fff8);
    step();
    check("run_inst0", inst, 32'h0);
    check("run_valid0", {31'b0, instValid}, 32'd1);
    check("run_addr4", imemAddr, 32'h4);
    check("wrap_inst0", inst2, 32'hffff_fff8);
    check("wrap_addr1", imemAddr2, 32'hffff_fffc);
    step();
    check("run_inst4", inst, 32'h4);
    check("run_pc4", pc, 32'h4);
    check("run_addr8", imemAddr, 32'h8);
    check("wrap_inst1", inst2, 32'hffff_fffc);
    check("wrap_addr2", imemAddr2, 32'h0);

    // Request at 8 waits one cycle, then response lands under stall -> SKID
    mem_wait = 1;
    step();
    check("wrap_inst2", inst2, 32'h0);
    check("wrap_valid2", {31'b0, instValid2}, 32'd1);
    check("bub_valid", {31'b0, instValid}, 32'd0);
    check("bub_addr8", imemAddr, 32'h8);
    stall = 1'b1; #1;
    check("pend_req", {31'b0, imemReq}, 32'd1);
    step();
    check("skid_req", {31'b0, imemReq}, 32'd0);
    check("skid_pc_hold", pc, 32'h4);
    check("skid_valid", {31'b0, instValid}, 32'd0);
    step();
    check("skid_req_hold", {31'b0, imemReq}, 32'd0);
    stall = 1'b0; mem_wait = 0;
    step();
    check("unskid_inst", inst, 32'h8);
    check("unskid_pc", pc, 32'h8);
    check("unskid_valid", {31'b0, instValid}, 32'd1);
    check("resume_addr", imemAddr, 32'hc);
    step();
    check("resume_inst", inst, 32'hc);
    check("next_addr10", imemAddr, 32'h10);

    // 3-cycle wait at 0x10, jump to 0x100 in the first wait cycle
    mem_wait = 3; #1;
    check("w_notready", {31'b0, imemReady}, 32'd0);
    jumpEn = 1'b1; jumpAddr = 32'h100;
    step();
    jumpEn = 1'b0;
    check("drain_addr1", imemAddr, 32'h10);
    check("drain_req1", {31'b0, imemReq}, 32'd1);
    check("drain_valid1", {31'b0, instValid}, 32'd0);
    step();
    check("drain_addr2", imemAddr, 32'h10);
    step();
    check("drain_addr3", imemAddr, 32'h10);
    check("drain_ready", {31'b0, imemReady}, 32'd1);
    step();
    mem_wait = 1;
    check("redir_addr", imemAddr, 32'h100);
    check("redir_valid", {31'b0, instValid}, 32'd0);
    step();
    check("redir_wait_valid", {31'b0, instValid}, 32'd0);
    check("redir_wait_addr", imemAddr, 32'h100);
    step();
    check("redir_inst", inst, 32'h100);
    check("redir_pc", pc, 32'h100);
    check("redir_ivalid", {31'b0, instValid}, 32'd1);
    check("redir_next", imemAddr, 32'h104);

    // Into SKID at 0x104, then jump to 0x203
    step();
    stall = 1'b1;
    step();
    check("skid2_req", {31'b0, imemReq}, 32'd0);
    jumpEn = 1'b1; jumpAddr = 32'h203;
    step();
    jumpEn = 1'b0; stall = 1'b0; mem_wait = 0; #1;
    check("sj_valid", {31'b0, instValid}, 32'd0);
    check("sj_addr", imemAddr, 32'h200);
    check("sj_req", {31'b0, imemReq}, 32'd1);
    step();
    check("sj_inst", inst, 32'h200);
    check("sj_ivalid", {31'b0, instValid}, 32'd1);

    // Jump in FETCH with the response arriving: response dropped
    jumpEn = 1'b1; jumpAddr = 32'h40;
    step();
    jumpEn = 1'b0;
    check("jr_valid", {31'b0, instValid}, 32'd0);
    check("jr_inst", inst, 32'h0);
    check("jr_addr", imemAddr, 32'h40);
    step();
    check("jr_inst40", inst, 32'h40);

    // Stall with nothing pending: no request, outputs hold
    stall = 1'b1; #1;
    check("st_req", {31'b0, imemReq}, 32'd0);
    step();
    check("st_inst", inst, 32'h40);
    check("st_valid", {31'b0, instValid}, 32'd1);
    stall = 1'b0;

    // Reset while a request to 0x44 is outstanding
    mem_wait = 2;
    step();
    check("rm_pend_addr", imemAddr, 32'h44);
    rst = 1'b1; #1;
    check("rm_req_rst", {31'b0, imemReq}, 32'd0);
    step();
    check("rm_valid", {31'b0, instValid}, 32'd0);
    rst = 1'b0; mem_wait = 0; #1;
    check("rm_addr", imemAddr, 32'h0);
    check("rm_req", {31'b0, imemReq}, 32'd1);
    step();
    check("rm_inst", inst, 32'h0);
    check("rm_ivalid", {31'b0, instValid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
